vga_ram_scroll_engine: RTL and testbench

- Controller and arbiter for port A (clka side) of the 2048x32 VGA text RAM.
- Shares port A between the CPU bus and a hardware engine that runs two bulk operations on a text window: scroll up by one row (copy, then blank the last row) and clear/fill of the whole window.
- Port B (scanout) is not touched.
- Sits between the CPU memory decoder and the RAM's port A.

---
 rtl/vga_ram_scroll_engine.sv | 164 ++++++++++++++++
 tb/tb_vga_ram_scroll_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ram_scroll_engine.sv
// vga_ram_scroll_engine: port A controller for the 2048x32 VGA text RAM.
// Muxes CPU accesses with a background engine that scrolls the text window
// up by one row (copy rows 1..N-1 onto 0..N-2, then blank the last row) or
// fills the whole window. The CPU always wins the port; the engine only
// uses cycles where cpu_en is low, so CPU accesses never stall.
module vga_ram_scroll_engine #(
    parameter int BASE_ADDR = 0,
    parameter int ROW_WORDS = 20,
    parameter int ROWS      = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_fill,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [10:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    localparam int WIN_WORDS  = ROWS * ROW_WORDS;
    localparam int COPY_WORDS = (ROWS - 1) * ROW_WORDS;

    // The window must fit inside the RAM and hold at least one row.
    if (ROWS < 1 || ROW_WORDS < 1 || BASE_ADDR < 0 ||
        BASE_ADDR + WIN_WORDS > 2048) begin : g_range_err
        $error("vga_ram_scroll_engine: window does not fit in 2048-word RAM");
    end

    localparam logic [10:0] BASE      = 11'(BASE_ADDR);
    localparam logic [10:0] ROW_OFS   = 11'(ROW_WORDS);
    // Unreachable value when COPY_WORDS is 0; scroll then skips the copy phase.
    localparam logic [10:0] COPY_LAST = 11'(COPY_WORDS - 1);
    localparam logic [10:0] WIN_LAST  = 11'(WIN_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_FILL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [10:0] addr;
        logic [31:0] wd;
    } port_req_t;

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [31:0] fill_q, fill_d;

    port_req_t   cpu_req, eng_req, ram_req;

    // State, word index, copy buffer and fill word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    // Engine sequencing: every access step waits in place while the CPU owns the port.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        fill_d  = fill_q;
        eng_req = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    idx_d  = '0;
                    fill_d = cmd_fill;
                    case (cmd_op)
                        2'b00:   state_d = (COPY_WORDS == 0) ? S_FILL : S_RD;
                        2'b01:   state_d = S_FILL;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_RD: begin
                if (!cpu_en) begin
                    eng_req.en   = 1'b1;
                    eng_req.addr = BASE + ROW_OFS + idx_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data belongs to the RD issued last cycle, whoever owns the port now.
                data_d  = ram_rd;
                state_d = S_WR;
            end
            S_WR: begin
                if (!cpu_en) begin
                    eng_req.en   = 1'b1;
                    eng_req.we   = 4'b1111;
                    eng_req.addr = BASE + idx_q;
                    eng_req.wd   = data_q;
                    idx_d        = idx_q + 11'd1;
                    // Index lands on the first word of the last row, ready for the blank.
                    state_d      = (idx_q == COPY_LAST) ? S_FILL : S_RD;
                end
            end
            S_FILL: begin
                if (!cpu_en) begin
                    eng_req.en   = 1'b1;
                    eng_req.we   = 4'b1111;
                    eng_req.addr = BASE + idx_q;
                    eng_req.wd   = fill_q;
                    idx_d        = idx_q + 11'd1;
                    state_d      = (idx_q == WIN_LAST) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port A mux: the CPU takes priority unconditionally.
    always_comb begin
        cpu_req.en   = cpu_en;
        cpu_req.we   = cpu_we;
        cpu_req.addr = cpu_addr;
        cpu_req.wd   = cpu_wd;
        ram_req      = cpu_en ? cpu_req : eng_req;
    end

    assign ram_en    = ram_req.en;
    assign ram_we    = ram_req.we;
    assign ram_addr  = ram_req.addr;
    assign ram_wd    = ram_req.wd;
    assign cpu_rd    = ram_rd;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_vga_ram_scroll_engine.sv
// Bench for vga_ram_scroll_engine (4 words/row, 3 rows, base 0) with a
// registered-read RAM model on port A. Stimulus pushes expected done cycles
// and CPU read data into queues; a negedge monitor pops and compares.
module tb_vga_ram_scroll_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic [3:0]  cpu_we = 4'b0;
    logic [10:0] cpu_addr = '0;
    logic [31:0] cpu_wd = '0;
    logic [31:0] cpu_rd;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b0;
    logic [31:0] cmd_fill = '0;
    logic        cmd_ready, busy, done, ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd = '0;

    logic [31:0] mem [0:2047];
    int          ecnt = 0;
    int          total = 0;
    int          bad = 0;
    int          done_q[$];
    logic [31:0] rd_q[$];

    localparam logic [31:0] RD100 = 32'hC0FFEE64;

    vga_ram_scroll_engine #(.BASE_ADDR(0), .ROW_WORDS(4), .ROWS(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // RAM port A: we[3] -> byte [7:0] ... we[0] -> byte [31:24], registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rd <= mem[ram_addr];
            if (ram_we[3]) mem[ram_addr][7:0]   <= ram_wd[7:0];
            if (ram_we[2]) mem[ram_addr][15:8]  <= ram_wd[15:8];
            if (ram_we[1]) mem[ram_addr][23:16] <= ram_wd[23:16];
            if (ram_we[0]) mem[ram_addr][31:24] <= ram_wd[31:24];
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        cpu_en = 1'b0; cpu_we = 4'b0; cpu_addr = '0; cpu_wd = '0;
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d);
        cpu_en = 1'b1; cpu_we = 4'b1111; cpu_addr = 11'(a); cpu_wd = d;
        step();
        idle_cpu();
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) cpu_write(i, 32'(i));
        cpu_write(50, 32'h11223344);
        cpu_write(100, RD100);
    endtask

    // Raise cmd_valid until accepted; acc = ecnt value seen throughout cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] f, output int acc);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_fill = f;
        n = 0;
        while (!cmd_ready && n < 200) begin step(); n++; end
        if (n >= 200) chk1("issue_timeout", cmd_ready, 1'b1);
        step();
        acc = ecnt;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((done_q.size() != 0 || busy) && n < 300) begin step(); n++; end
        if (n >= 300) chk32(nm, 32'(done_q.size()), 32'd0);
        step();
    endtask

    task automatic chk_scrolled(input string nm, input logic [31:0] f);
        for (int i = 0; i < 8; i++) chk32(nm, mem[i], 32'(i + 4));
        for (int i = 8; i < 12; i++) chk32(nm, mem[i], f);
    endtask

    // Monitor: compare done timing and CPU read data as the DUT presents them.
    initial begin
        logic rp;
        rp = 1'b0;
        forever begin
            @(negedge clk);
            if (rp) begin
                if (rd_q.size() == 0) chk1("rd_unexpected", 1'b1, 1'b0);
                else chk32("cpu_rd", cpu_rd, rd_q.pop_front());
            end
            rp = cpu_en && (cpu_we == 4'b0) && !rst;
            if (done) begin
                if (done_q.size() == 0) chk1("done_unexpected", done, 1'b0);
                else chk32("done_cycle", 32'(ecnt), 32'(done_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2, a3, n;
        // Reset state
        step(); step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ram_en0", ram_en, 1'b0);
        cpu_en = 1'b1; cpu_we = 4'b1111; cpu_addr = 11'd200; cpu_wd = 32'h5;
        #1;
        chk1("rst_ram_en1", ram_en, 1'b1);
        chk32("rst_ram_addr", 32'(ram_addr), 32'd200);
        step();
        idle_cpu();
        rst = 1'b0;
        preload();

        // 1: scroll, no CPU traffic
        issue(2'b00, 32'h20202020, a1);
        done_q.push_back(a1 + 28);
        for (int k = 1; k <= 30; k++) begin
            chk1("t1_busy", busy, k <= 29);
            chk1("t1_ready", cmd_ready, k >= 30);
            step();
        end
        wait_idle("t1_wait");
        chk_scrolled("t1_mem", 32'h20202020);

        // 2: fill
        issue(2'b01, 32'hDEADBEEF, a1);
        done_q.push_back(a1 + 12);
        wait_idle("t2_wait");
        for (int i = 0; i < 12; i++) chk32("t2_mem", mem[i], 32'hDEADBEEF);
        chk32("t2_mem12", mem[12], 32'd12);

        // 3: scroll with CPU reads of addr 100 in cycles 3,6,..,30 (strobes at 3,27,30 stall)
        preload();
        issue(2'b00, 32'h20202020, a1);
        done_q.push_back(a1 + 31);
        for (int k = 1; k <= 33; k++) begin
            if (k % 3 == 0 && k <= 30) begin
                cpu_en = 1'b1; cpu_we = 4'b0; cpu_addr = 11'd100;
                rd_q.push_back(RD100);
            end else begin
                idle_cpu();
            end
            step();
        end
        idle_cpu();
        wait_idle("t3_wait");
        chk_scrolled("t3_mem", 32'h20202020);
        chk32("t3_rd_q", 32'(rd_q.size()), 32'd0);

        // 4: command held during a fill; accepted the cycle after done; then a no-op
        preload();
        issue(2'b01, 32'h55AA55AA, a1);
        done_q.push_back(a1 + 12);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_fill = 32'h0F0F0F0F;
        n = 0;
        while (!cmd_ready && n < 200) begin
            chk1("t4_ready_low", cmd_ready, 1'b0);
            step(); n++;
        end
        step();
        a2 = ecnt;
        cmd_valid = 1'b0;
        chk32("t4_accept_cycle", 32'(a2), 32'(a1 + 14));
        done_q.push_back(a2 + 28);
        wait_idle("t4_wait");
        for (int i = 0; i < 8; i++) chk32("t4_mem", mem[i], 32'h55AA55AA);
        for (int i = 8; i < 12; i++) chk32("t4_mem", mem[i], 32'h0F0F0F0F);
        issue(2'b11, 32'h12345678, a3);
        done_q.push_back(a3);
        wait_idle("t4_noop_wait");
        chk32("t4_noop_mem0", mem[0], 32'h55AA55AA);
        chk32("t4_noop_mem11", mem[11], 32'h0F0F0F0F);

        // 5: reset in cycle 10 of a scroll
        preload();
        issue(2'b00, 32'h20202020, a1);
        for (int k = 1; k <= 9; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_ready", cmd_ready, 1'b1);
        chk1("t5_done", done, 1'b0);
        cpu_en = 1'b1; cpu_we = 4'b0; cpu_addr = 11'd100;
        rd_q.push_back(RD100);
        #1;
        chk1("t5_ram_en1", ram_en, 1'b1);
        step();
        idle_cpu();
        #1;
        chk1("t5_ram_en0", ram_en, 1'b0);
        for (int k = 0; k < 40; k++) step();

        // 6: CPU byte write during the first engine WR (cycle 3)
        preload();
        issue(2'b00, 32'h20202020, a1);
        done_q.push_back(a1 + 29);
        step(); step();
        cpu_en = 1'b1; cpu_we = 4'b0001; cpu_addr = 11'd50; cpu_wd = 32'hAB000000;
        #1;
        chk32("t6_cpu_we", 32'(ram_we), 32'h1);
        chk32("t6_cpu_addr", 32'(ram_addr), 32'd50);
        step();
        idle_cpu();
        #1;
        chk32("t6_eng_we", 32'(ram_we), 32'hF);
        chk32("t6_eng_addr", 32'(ram_addr), 32'd0);
        chk32("t6_eng_wd", ram_wd, 32'd4);
        wait_idle("t6_wait");
        chk32("t6_mem50", mem[50], 32'hAB223344);
        chk_scrolled("t6_mem", 32'h20202020);

        chk32("end_done_q", 32'(done_q.size()), 32'd0);
        chk32("end_rd_q", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
